// File: rtl/chunked_subtractor_if.sv
// chunked_subtractor_if: request/result bundle for the slice-serial subtractor.
interface chunked_subtractor_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: W-bit unsigned subtract, one N-bit slice per clock, LSB slice first.
module chunked_subtractor #(
    parameter int W = 16,
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 rst_,
    chunked_subtractor_if.slave bus
);
    localparam int S  = W / N;
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic            brw_q, brw_d, borrow_q, borrow_d, zero_q, zero_d, done_q, done_d;
    logic [N:0]      slice;
    logic [W+N-1:0]  res_cat;
    logic            last;

    // Borrow ripples between cycles through brw_q, never wider than one slice.
    assign slice   = {1'b0, a_q[N-1:0]} - {1'b0, b_q[N-1:0]} - {{N{1'b0}}, brw_q};
    assign res_cat = {slice[N-1:0], res_q};
    assign last    = cnt_q == CW'(S - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = bus.a;
                b_d     = bus.b;
                res_d   = '0;
                brw_d   = 1'b0;
            end
        end else begin
            a_d   = a_q >> N;
            b_d   = b_q >> N;
            res_d = res_cat[W+N-1:N];
            brw_d = slice[N];
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d  = IDLE;
                cnt_d    = '0;
                diff_d   = res_cat[W+N-1:N];
                borrow_d = slice[N];
                zero_d   = res_cat[W+N-1:N] == '0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = state_q == RUN;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed and random checks of three slice widths against plain arithmetic.
module tb_chunked_subtractor;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [2:0]  go = '0;
    logic [15:0] a_v = '0;
    logic [15:0] b_v = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    chunked_subtractor_if #(.W(16)) ifa ();
    chunked_subtractor_if #(.W(16)) ifb ();
    chunked_subtractor_if #(.W(16)) ifc ();

    assign ifa.start = go[0];
    assign ifb.start = go[1];
    assign ifc.start = go[2];
    assign ifa.a = a_v;
    assign ifb.a = a_v;
    assign ifc.a = a_v;
    assign ifa.b = b_v;
    assign ifb.b = b_v;
    assign ifc.b = b_v;

    chunked_subtractor #(.W(16), .N(4))  dut_a (.clk(clk), .rst_(rst_), .bus(ifa.slave));
    chunked_subtractor #(.W(16), .N(1))  dut_b (.clk(clk), .rst_(rst_), .bus(ifb.slave));
    chunked_subtractor #(.W(16), .N(16)) dut_c (.clk(clk), .rst_(rst_), .bus(ifc.slave));

    // {busy, done, borrow, zero, diff}
    function automatic logic [19:0] obs(int s);
        case (s)
            0:       return {ifa.busy, ifa.done, ifa.borrow, ifa.zero, ifa.diff};
            1:       return {ifb.busy, ifb.done, ifb.borrow, ifb.zero, ifb.diff};
            default: return {ifc.busy, ifc.done, ifc.borrow, ifc.zero, ifc.diff};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input int s, input logic [15:0] x, input logic [15:0] y, input bit b2b, input string tag);
        int          sl;
        int          lat;
        int          bsy;
        logic [19:0] o;
        logic [15:0] ed;
        sl  = (s == 0) ? 4 : (s == 1) ? 16 : 1;
        lat = -1;
        bsy = 0;
        ed  = x - y;
        o   = '0;
        if (!b2b) @(negedge clk);
        a_v   = x;
        b_v   = y;
        go[s] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            go[s] = 1'b0;
            a_v   = 16'($urandom);
            b_v   = 16'($urandom);
            o     = obs(s);
            if (o[19]) bsy++;
            if (o[18]) begin
                lat = k - 1;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(sl));
        chk({tag, " busy_cycles"}, 32'(bsy), 32'(sl));
        chk({tag, " diff"}, 32'(o[15:0]), 32'(ed));
        chk({tag, " borrow"}, 32'(o[17]), 32'(x < y));
        chk({tag, " zero"}, 32'(o[16]), 32'(ed == 16'h0));
    endtask

    initial begin
        logic [19:0] o;
        logic [15:0] acc_a [4];
        logic [15:0] acc_b [4];
        logic [15:0] x, y, ed;
        int          nd;

        @(negedge clk);
        chk("reset dut_a", 32'(obs(0)), 32'h0);
        chk("reset dut_b", 32'(obs(1)), 32'h0);
        chk("reset dut_c", 32'(obs(2)), 32'h0);
        rst_ = 1'b1;

        op(0, 16'h1234, 16'h0234, 1'b0, "basic");
        chk("basic known diff", 32'(obs(0) & 20'hFFFF), 32'h1000);
        op(0, 16'h1000, 16'h0001, 1'b0, "ripple");
        op(0, 16'h0000, 16'h0001, 1'b0, "underflow");
        op(0, 16'hABCD, 16'hABCD, 1'b0, "equal");
        op(0, 16'h0005, 16'h0003, 1'b1, "b2b");
        chk("b2b known diff", 32'(obs(0) & 20'hFFFF), 32'h0002);

        // Results must hold while idle and operands wander.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_v = 16'($urandom);
            b_v = 16'($urandom);
            o   = obs(0);
            chk("hold diff", 32'(o[15:0]), 32'h0002);
            chk("hold done", 32'(o[18]), 32'h0);
        end

        // Start held high with operands changing every cycle: accepts only every S+1 cycles.
        @(negedge clk);
        a_v      = 16'h7F00;
        b_v      = 16'h0100;
        acc_a[0] = a_v;
        acc_b[0] = b_v;
        go[0]    = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            o = obs(0);
            chk("streaming done", 32'(o[18]), 32'(k % 5 == 0));
            if (k % 5 == 0) begin
                ed = acc_a[k/5-1] - acc_b[k/5-1];
                chk("streaming diff", 32'(o[15:0]), 32'(ed));
                chk("streaming borrow", 32'(o[17]), 32'(acc_a[k/5-1] < acc_b[k/5-1]));
            end
            if (k == 15) go[0] = 1'b0;
            a_v = 16'($urandom);
            b_v = 16'($urandom);
            if (k % 5 == 0) begin
                acc_a[k/5] = a_v;
                acc_b[k/5] = b_v;
            end
        end

        // Reset mid-operation after three slices have been consumed.
        @(negedge clk);
        a_v   = 16'h4321;
        b_v   = 16'h1111;
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("abort async", 32'(obs(0)), 32'h0);
        repeat (2) @(negedge clk);
        chk("abort held", 32'(obs(0)), 32'h0);
        rst_ = 1'b1;
        nd   = 0;
        repeat (8) begin
            @(negedge clk);
            o = obs(0);
            if (o[18]) nd++;
        end
        chk("abort no done", 32'(nd), 32'h0);
        chk("abort outputs", 32'(obs(0)), 32'h0);
        op(0, 16'h0010, 16'h0001, 1'b0, "after abort");

        op(1, 16'h0000, 16'hFFFF, 1'b0, "n1 edge");
        op(2, 16'hFFFF, 16'hFFFF, 1'b0, "n16 edge");
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = (i % 50 == 0) ? x : 16'($urandom);
            op(1, x, y, 1'b0, "random n1");
            op(2, x, y, 1'b0, "random n16");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
